// File: rtl/fir_ctrl_mc_loader_pkg.sv
// Shared types and constants for the FIR coefficient loader.
package fir_ctrl_mc_loader_pkg;

  localparam int unsigned PARA_W          = 32;
  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned TRACK_W         = 32;
  localparam int unsigned DEF_BURST_WORDS = 128;
  localparam int unsigned HDR_TRACK       = 0;
  localparam int unsigned HDR_DS          = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR0,
    ST_HDR1,
    ST_TAPS,
    ST_DRAIN,
    ST_COMMIT,
    ST_ERR
  } state_e;

  // States in which the parameter FIFO is being read.
  function automatic logic is_fetch(input state_e s);
    return (s == ST_REQ) || (s == ST_HDR0) || (s == ST_HDR1) ||
           (s == ST_TAPS) || (s == ST_DRAIN);
  endfunction

  // States guarded by the inter-word timeout.
  function automatic logic is_timed(input state_e s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_TAPS) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/fir_ctrl_mc_loader_reg_delay.sv
// Fixed-depth shift-register delay line with synchronous reset.
module fir_ctrl_mc_loader_reg_delay
  import fir_ctrl_mc_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fir_ctrl_mc_loader.sv
// FIR control: loads coefficient bursts into the shadow bank, commits at frame boundaries,
// and aligns flags/raw data with the external FIR engine output.
module fir_ctrl_mc_loader
  import fir_ctrl_mc_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned TAP_WIDTH    = 32,
  parameter int unsigned TAP_NUM      = 51,
  parameter int unsigned BURST_WORDS  = DEF_BURST_WORDS,
  parameter int unsigned DS_WIDTH     = 8,
  parameter int unsigned FIR_LATENCY  = 102,
  parameter int unsigned FLAG_LATENCY = 127,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  laser_fir_en_i,
  input  logic                  laser_fir_upmode_i,
  input  logic                  laser_start_i,
  input  logic                  zero_flag_i,
  input  logic                  acc_flag_i,
  output logic                  fir_tap_para_ren_o,
  input  logic                  fir_tap_para_vld_i,
  input  logic [PARA_W-1:0]     fir_tap_para_data_i,
  output logic                  fir_tap_vld_o,
  output logic                  fir_tap_bank_o,
  output logic [ADDR_W-1:0]     fir_tap_addr_o,
  output logic [TAP_WIDTH-1:0]  fir_tap_data_o,
  output logic                  fir_bank_sel_o,
  output logic [DS_WIDTH-1:0]   fir_down_sample_num_o,
  output logic [TRACK_W-1:0]    track_addr_o,
  input  logic                  laser_vld_i,
  input  logic [DATA_WIDTH-1:0] laser_data_i,
  input  logic                  m_axis_fir_tvalid_i,
  input  logic [DATA_WIDTH-1:0] m_axis_fir_tdata_i,
  output logic                  fir_zero_flag_o,
  output logic                  fir_acc_flag_o,
  output logic                  fir_laser_vld_o,
  output logic [DATA_WIDTH-1:0] fir_laser_data_o,
  output logic                  load_busy_o,
  output logic                  load_done_o,
  output logic                  load_err_o
);

  localparam int unsigned WCNT_W = $clog2(BURST_WORDS + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

  state_e               state_q, state_d;
  logic                 start_q;
  logic                 pending_q, pending_d;
  logic                 bad_q, bad_d;
  logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]    tap_cnt_q, tap_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [TRACK_W-1:0]   sh_track_q, sh_track_d;
  logic [DS_WIDTH-1:0]  sh_ds_q, sh_ds_d;
  logic                 trig_c, commit_ok_c, word_last_c, tap_wr_c, commit_c;

  logic                 ren_q, tap_vld_q, tap_bank_q, bank_sel_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0]    tap_addr_q;
  logic [TAP_WIDTH-1:0] tap_data_q;
  logic [DS_WIDTH-1:0]  ds_q;
  logic [TRACK_W-1:0]   track_q;

  assign trig_c      = laser_fir_en_i & ((laser_start_i & ~start_q) | zero_flag_i);
  assign commit_ok_c = laser_fir_en_i & (zero_flag_i | ~laser_start_i);
  assign word_last_c = (word_cnt_q == WCNT_W'(BURST_WORDS - 1));

  // Next-state and counter logic for the header/tap/drain sequence.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    bad_d      = bad_q;
    word_cnt_d = word_cnt_q;
    tap_cnt_d  = tap_cnt_q;
    to_cnt_d   = to_cnt_q;
    sh_track_d = sh_track_q;
    sh_ds_d    = sh_ds_q;
    tap_wr_c   = 1'b0;
    commit_c   = 1'b0;

    if ((state_q != ST_IDLE) && trig_c) pending_d = 1'b1;

    if (is_timed(state_q)) begin
      if (fir_tap_para_vld_i) begin
        to_cnt_d   = '0;
        word_cnt_d = word_cnt_q + WCNT_W'(1);
      end else begin
        to_cnt_d   = to_cnt_q + TO_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: if (trig_c) state_d = ST_REQ;
      ST_REQ: begin
        word_cnt_d = '0;
        tap_cnt_d  = '0;
        to_cnt_d   = '0;
        bad_d      = 1'b0;
        state_d    = ST_HDR0;
      end
      ST_HDR0: if (fir_tap_para_vld_i) begin
        sh_track_d = TRACK_W'(fir_tap_para_data_i);
        state_d    = ST_HDR1;
      end
      ST_HDR1: if (fir_tap_para_vld_i) begin
        sh_ds_d = fir_tap_para_data_i[DS_WIDTH-1:0];
        if (fir_tap_para_data_i[DS_WIDTH-1:0] == '0) bad_d = 1'b1;
        state_d = ST_TAPS;
      end
      ST_TAPS: if (fir_tap_para_vld_i) begin
        tap_wr_c  = 1'b1;
        tap_cnt_d = tap_cnt_q + ADDR_W'(1);
        if (tap_cnt_q == ADDR_W'(TAP_NUM - 1)) begin
          if (word_last_c) state_d = bad_q ? ST_ERR : ST_COMMIT;
          else             state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (fir_tap_para_vld_i && word_last_c) state_d = bad_q ? ST_ERR : ST_COMMIT;
      // The zero flag that performs the commit is consumed, not queued.
      ST_COMMIT: if (commit_ok_c) begin
        commit_c  = 1'b1;
        pending_d = 1'b0;
        state_d   = pending_q ? ST_REQ : ST_IDLE;
      end
      ST_ERR: begin
        pending_d = 1'b0;
        state_d   = (pending_q | trig_c) ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (is_timed(state_q) && !fir_tap_para_vld_i && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)))
      state_d = ST_ERR;
  end

  // FSM state and load bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      pending_q  <= 1'b0;
      bad_q      <= 1'b0;
      word_cnt_q <= '0;
      tap_cnt_q  <= '0;
      to_cnt_q   <= '0;
      sh_track_q <= '0;
      sh_ds_q    <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= laser_start_i;
      pending_q  <= pending_d;
      bad_q      <= bad_d;
      word_cnt_q <= word_cnt_d;
      tap_cnt_q  <= tap_cnt_d;
      to_cnt_q   <= to_cnt_d;
      sh_track_q <= sh_track_d;
      sh_ds_q    <= sh_ds_d;
    end
  end

  // Control outputs: tap write port, committed bank/header values, status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ren_q      <= 1'b0;
      tap_vld_q  <= 1'b0;
      tap_bank_q <= 1'b0;
      tap_addr_q <= '0;
      tap_data_q <= '0;
      bank_sel_q <= 1'b0;
      ds_q       <= '0;
      track_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ren_q     <= is_fetch(state_d);
      busy_q    <= (state_d != ST_IDLE);
      tap_vld_q <= tap_wr_c;
      done_q    <= commit_c;
      if (tap_wr_c) begin
        tap_bank_q <= ~bank_sel_q;
        tap_addr_q <= tap_cnt_q;
        tap_data_q <= TAP_WIDTH'(fir_tap_para_data_i);
      end
      if (commit_c) begin
        bank_sel_q <= ~bank_sel_q;
        ds_q       <= sh_ds_q;
        track_q    <= sh_track_q;
      end
      if (state_q == ST_ERR)      err_q <= 1'b1;
      else if (state_q == ST_REQ) err_q <= 1'b0;
    end
  end

  // Output datapath: bypass, filtered, or filtered/raw interleave.
  logic [1:0]            flag_dly;
  logic [DATA_WIDTH-1:0] raw_dly;
  logic                  upm_c, sel_q;
  logic                  zf_q, af_q, vld_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign upm_c = laser_fir_en_i & laser_fir_upmode_i;

  fir_ctrl_mc_loader_reg_delay #(.WIDTH(2), .DEPTH(FLAG_LATENCY)) u_flag_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({zero_flag_i, acc_flag_i}),
    .q_o   (flag_dly)
  );

  fir_ctrl_mc_loader_reg_delay #(.WIDTH(DATA_WIDTH), .DEPTH(FIR_LATENCY)) u_raw_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (laser_data_i),
    .q_o   (raw_dly)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q  <= 1'b0;
      zf_q   <= 1'b0;
      af_q   <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      if (!upm_c)                   sel_q <= 1'b0;
      else if (m_axis_fir_tvalid_i) sel_q <= ~sel_q;
      if (!laser_fir_en_i) begin
        vld_q  <= laser_vld_i;
        data_q <= laser_data_i;
        zf_q   <= zero_flag_i;
        af_q   <= acc_flag_i;
      end else begin
        vld_q  <= m_axis_fir_tvalid_i;
        data_q <= (upm_c && sel_q) ? raw_dly : m_axis_fir_tdata_i;
        zf_q   <= flag_dly[1];
        af_q   <= flag_dly[0];
      end
    end
  end

  assign fir_tap_para_ren_o    = ren_q;
  assign fir_tap_vld_o         = tap_vld_q;
  assign fir_tap_bank_o        = tap_bank_q;
  assign fir_tap_addr_o        = tap_addr_q;
  assign fir_tap_data_o        = tap_data_q;
  assign fir_bank_sel_o        = bank_sel_q;
  assign fir_down_sample_num_o = ds_q;
  assign track_addr_o          = track_q;
  assign fir_zero_flag_o       = zf_q;
  assign fir_acc_flag_o        = af_q;
  assign fir_laser_vld_o       = vld_q;
  assign fir_laser_data_o      = data_q;
  assign load_busy_o           = busy_q;
  assign load_done_o           = done_q;
  assign load_err_o            = err_q;

endmodule
